fifo_fwft_reader: RTL and testbench

FIFO_FWFT_READER -- requirements
Module: fifo_fwft_reader

---
 rtl/fifo_fwft_reader_pkg.sv | 16 +
 rtl/fifo_fwft_reader.sv | 151 +++++++++++++++
 tb/tb_fifo_fwft_reader.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_reader_pkg.sv
// Shared types and helpers for the FWFT FIFO block reader.
//   state_t  : reader FSM states (IDLE, READ)
//   calc_lw  : width of a length/count field able to hold 0..max_words
package fifo_fwft_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Bits needed to represent every value from 0 to max_words inclusive.
  function automatic int unsigned calc_lw(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/fifo_fwft_reader.sv
// Reads one block of up to MAX_BLOCK_SIZE words from a first-word-fall-through
// FIFO and presents the captured block as a flat vector.
//
// Build option: define FIFO_FWFT_READER_THROTTLE_EN to add the gap input,
// which holds rden low for gap cycles after every pop.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   din     : FIFO head word, valid while empty is low
//   empty   : FIFO empty flag
//   rden    : FIFO pop (combinational)
//   start   : one-cycle request to read a block
//   length  : words requested, sampled when start is accepted in IDLE
//   busy    : block read in progress
//   done    : one-cycle pulse after the block completes
//   count   : words captured in the current or last block
//   data_o  : captured block, word i at [i*WIDTH +: WIDTH]
//   gap     : (throttle build only) idle cycles forced after each pop
module fifo_fwft_reader
  import fifo_fwft_reader_pkg::*;
#(
  parameter int unsigned  WIDTH          = 32,
  parameter int unsigned  MAX_BLOCK_SIZE = 32,
  localparam int unsigned LW             = calc_lw(MAX_BLOCK_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                din,
  input  logic                            empty,
  output logic                            rden,
  input  logic                            start,
  input  logic [LW-1:0]                   length,
  output logic                            busy,
  output logic                            done,
  output logic [LW-1:0]                   count,
  output logic [MAX_BLOCK_SIZE*WIDTH-1:0] data_o
`ifdef FIFO_FWFT_READER_THROTTLE_EN
  ,
  input  logic [3:0]                      gap
`endif
);

  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BLOCK_SIZE);

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic   [LW-1:0]                   r_len;
  logic   [LW-1:0]                   r_count;
  logic                              r_done;
  logic   [MAX_BLOCK_SIZE*WIDTH-1:0] r_data;

  logic                              w_permit;
  logic                              w_pop;
  logic                              w_accept;
  logic                              w_zero_req;
  logic                              w_last;
  logic   [LW-1:0]                   w_len_clamped;

`ifdef FIFO_FWFT_READER_THROTTLE_EN
  // Cool-down counter: loaded with gap on each pop, pops allowed only at zero.
  logic [3:0] r_gap_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap_cnt <= 4'd0;
    end else if (w_pop) begin
      r_gap_cnt <= gap;
    end else if (r_gap_cnt != 4'd0) begin
      r_gap_cnt <= r_gap_cnt - 4'd1;
    end
  end

  assign w_permit = (r_gap_cnt == 4'd0);
`else
  assign w_permit = 1'b1;
`endif

  // Oversized requests are trimmed to the capture buffer depth.
  assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_zero_req  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            w_zero_req = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        // start is deliberately not looked at here.
        w_pop  = ~empty & (r_count < r_len) & w_permit;
        w_last = w_pop & ((r_count + LW'(1)) == r_len);
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Block length, capture buffer, word count and completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last | w_zero_req;
      if (w_accept) begin
        r_len   <= w_len_clamped;
        r_count <= '0;
        r_data  <= '0;
      end else if (w_zero_req) begin
        r_count <= '0;
      end else if (w_pop) begin
        r_data[int'(r_count) * WIDTH +: WIDTH] <= din;
        r_count <= r_count + LW'(1);
      end
    end
  end

  assign rden   = w_pop;
  assign busy   = (r_state == READ);
  assign done   = r_done;
  assign count  = r_count;
  assign data_o = r_data;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Self-checking bench for fifo_fwft_reader: a block-level reference model
// compared against the DUT on every falling edge, plus directed scenarios
// with hand-computed expectations.
module tb_fifo_fwft_reader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned MAXB  = 32;
  localparam int unsigned LW    = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [WIDTH-1:0]       din;
  logic                   empty = 1'b1;
  logic                   rden;
  logic                   start = 1'b0;
  logic [LW-1:0]          length = '0;
  logic                   busy;
  logic                   done;
  logic [LW-1:0]          count;
  logic [MAXB*WIDTH-1:0]  data_o;
  logic [3:0]             gap = 4'd0;

  fifo_fwft_reader #(.WIDTH(WIDTH), .MAX_BLOCK_SIZE(MAXB)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .empty  (empty),
    .rden   (rden),
    .start  (start),
    .length (length),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .data_o (data_o)
`ifdef FIFO_FWFT_READER_THROTTLE_EN
    ,
    .gap    (gap)
`endif
  );

  always #5 clk = ~clk;

  // FIFO source: the k-th word popped is 0x1000 + k.
  logic [31:0] k = '0;
  logic        k_clr = 1'b0;
  assign din = 32'h1000 + k;
  always @(posedge clk) begin
    if (k_clr)     k <= '0;
    else if (rden) k <= k + 32'd1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  int          m_len   = 0;
  int          m_count = 0;
  int          m_cool  = 0;
  logic [31:0] m_data [MAXB];

  function automatic int gap_in();
`ifdef FIFO_FWFT_READER_THROTTLE_EN
    return int'(gap);
`else
    return 0;
`endif
  endfunction

  function automatic logic m_rden();
    return m_busy && !empty && (m_count < m_len) && (m_cool == 0);
  endfunction

  task automatic m_clear();
    m_busy = 1'b0; m_done = 1'b0; m_len = 0; m_count = 0; m_cool = 0;
    for (int i = 0; i < MAXB; i++) m_data[i] = '0;
  endtask

  initial m_clear();

  always @(negedge rst) m_clear();

  always @(posedge clk) begin
    if (rst) begin
      logic pop;
      logic done_n;
      pop    = m_rden();
      done_n = 1'b0;
      if (!m_busy) begin
        if (start) begin
          if (length == '0) begin
            done_n  = 1'b1;
            m_count = 0;
          end else begin
            m_len   = (int'(length) > MAXB) ? MAXB : int'(length);
            m_count = 0;
            m_busy  = 1'b1;
            for (int i = 0; i < MAXB; i++) m_data[i] = '0;
          end
        end
      end else if (pop) begin
        m_data[m_count] = din;
        m_count++;
        if (m_count == m_len) begin
          m_busy = 1'b0;
          done_n = 1'b1;
        end
      end
      if (pop) m_cool = gap_in();
      else if (m_cool > 0) m_cool--;
      m_done = done_n;
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int pops, dones, bad_pop, first_pop, last_pop, done_cyc, busy_start;
  int pop_q[$];

  task automatic clear_obs();
    pops = 0; dones = 0; bad_pop = 0;
    first_pop = -1; last_pop = -1; done_cyc = -1; busy_start = -1;
    pop_q.delete();
  endtask

  initial clear_obs();

  always @(negedge clk) begin
    logic [MAXB*WIDTH-1:0] exp_flat;
    if (rst) begin
      for (int i = 0; i < MAXB; i++) exp_flat[i*WIDTH +: WIDTH] = m_data[i];
      chk("cyc_rden",  rden,  m_rden());
      chk("cyc_busy",  busy,  m_busy);
      chk("cyc_done",  done,  m_done);
      chk("cyc_count", count, m_count);
      n_chk++;
      if (data_o == exp_flat) n_pass++;
      else begin
        for (int i = 0; i < MAXB; i++)
          if (data_o[i*WIDTH +: WIDTH] != m_data[i]) begin
            $display("FAIL cyc_data word %0d: got %h expected %h at %0t",
                     i, data_o[i*WIDTH +: WIDTH], m_data[i], $time);
            break;
          end
      end
      if (busy && busy_start < 0) busy_start = cyc;
      if (rden) begin
        pops++;
        pop_q.push_back(cyc);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (empty) bad_pop++;
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_k();
    @(posedge clk); #1 k_clr = 1'b1;
    @(posedge clk); #1 k_clr = 1'b0;
  endtask

  task automatic go(input int len);
    @(posedge clk); #1 start = 1'b1; length = LW'(len);
    @(posedge clk); #1 start = 1'b0; length = '0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    while (dones == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, (dones > 0) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string nm, input int idx, input logic [31:0] exp);
    logic [31:0] w;
    w = data_o[idx*WIDTH +: WIDTH];
    chk(nm, w, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_rden", rden, 0);
    chk("rst_data_zero", (data_o == '0) ? 1 : 0, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 8-word block, FIFO never empty
    clr_k(); clear_obs(); empty = 1'b0;
    go(8);
    wait_done("blk8_done_seen", 30);
    chk("blk8_pops", pops, 8);
    chk("blk8_consecutive", last_pop - first_pop + 1, 8);
    chk("blk8_no_lead_bubble", first_pop, busy_start);
    chk("blk8_done_after_last", done_cyc, last_pop + 1);
    chk("blk8_done_once", dones, 1);
    chk("blk8_count", count, 8);
    for (int i = 0; i < 8; i++) chk_word("blk8_word", i, 32'h1000 + 32'(i));
    chk_word("blk8_word8_zero", 8, 32'h0);

    // 4-word block with empty toggling every cycle
    empty = 1'b1;
    clr_k(); clear_obs();
    go(4);
    begin
      int n;
      n = 0;
      while (dones == 0 && n < 40) begin
        @(posedge clk); #1 empty = ~empty;
        n++;
      end
      chk("tog_done_seen", (dones > 0) ? 1 : 0, 1);
    end
    empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("tog_pops", pops, 4);
    chk("tog_pop_while_empty", bad_pop, 0);
    chk("tog_done_once", dones, 1);
    chk("tog_count", count, 4);
    for (int i = 0; i < 4; i++) chk_word("tog_word", i, 32'h1000 + 32'(i));

    // Zero-length request
    empty = 1'b0;
    clear_obs();
    go(0);
    @(negedge clk);
    chk("zero_done_next", done, 1);
    chk("zero_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_pops", pops, 0);
    chk("zero_done_once", dones, 1);
    chk("zero_count", count, 0);

    // Oversized request clamps to 32; second start mid-block is ignored
    clr_k(); clear_obs();
    go(40);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; length = LW'(3);
    @(posedge clk);
    #1 start = 1'b0; length = '0;
    wait_done("big_done_seen", 80);
    chk("big_pops", pops, 32);
    chk("big_count", count, 32);
    chk("big_done_once", dones, 1);
    chk_word("big_word0", 0, 32'h1000);
    chk_word("big_word31", 31, 32'h101F);

    // Reset after 3 of 8 words, then a fresh 2-word block
    clr_k(); clear_obs();
    go(8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rden", rden, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data_zero", (data_o == '0) ? 1 : 0, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_pops", pops, 3);
    chk("mid_rst_no_done", dones, 0);
    clr_k(); clear_obs();
    go(2);
    wait_done("after_rst_done_seen", 20);
    chk("after_rst_count", count, 2);
    chk("after_rst_done_once", dones, 1);
    chk_word("after_rst_word0", 0, 32'h1000);
    chk_word("after_rst_word1", 1, 32'h1001);

`ifdef FIFO_FWFT_READER_THROTTLE_EN
    // gap=2, 3 words: pops on READ cycles 0, 3, 6; done on cycle 7
    repeat (4) @(posedge clk);
    #1;
    gap = 4'd2;
    clr_k(); clear_obs();
    go(3);
    wait_done("thr_done_seen", 30);
    chk("thr_pops", pops, 3);
    if (pop_q.size() == 3) begin
      chk("thr_pop0", pop_q[0] - busy_start, 0);
      chk("thr_pop1", pop_q[1] - busy_start, 3);
      chk("thr_pop2", pop_q[2] - busy_start, 6);
    end
    chk("thr_done_cycle", done_cyc - busy_start, 7);
    chk_word("thr_word2", 2, 32'h1002);
    gap = 4'd0;
`endif

    empty = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
